// File: rtl/audio_feed_sw_pkg.sv
// Shared defaults and types for the audio feed switch conditioner.
package audio_feed_sw_pkg;

    localparam int N_SW_DEFAULT         = 10;
    localparam int TICK_DIV_DEFAULT     = 50000;
    localparam int STABLE_TICKS_DEFAULT = 20;

    typedef logic [N_SW_DEFAULT-1:0] sw_vec_t;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/audio_feed_sw_debounce_tick.sv
// Free-running divider producing a one-cycle debounce tick every TICK_DIV cycles.
// Shared by the switch and key debouncers.
module sw_debounce_tick
    import audio_feed_sw_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] r_div;

    // Divider counter, wraps after the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/audio_feed_sw_debounce.sv
// Switch conditioner: two-flop synchronizer, shared tick, per-bit debounce counters.
// Optional one-cycle edge pulses are built when AUDIO_FEED_SW_DEBOUNCE_PULSE_EN is defined.
module audio_feed_sw_debounce
    import audio_feed_sw_pkg::*;
#(
    parameter int N_SW         = N_SW_DEFAULT,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_in,
    output logic [N_SW-1:0] sw_out,
    output logic            tick
`ifdef AUDIO_FEED_SW_DEBOUNCE_PULSE_EN
    ,
    output logic [N_SW-1:0] rise_pulse,
    output logic [N_SW-1:0] fall_pulse
`endif
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [N_SW-1:0] r_s1;
    logic [N_SW-1:0] r_s2;
    logic [N_SW-1:0] w_sw_out;
    logic            w_tick;

    sw_debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Two-flop synchronizer; only r_s2 is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_out;

        // Any cycle back at the current level cancels a pending change.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (r_s2[gi] == r_out) begin
                r_cnt <= '0;
            end else if (w_tick && (r_cnt == CNT_LAST)) begin
                r_out <= r_s2[gi];
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end

        assign w_sw_out[gi] = r_out;
    end

    assign sw_out = w_sw_out;
    assign tick   = w_tick;

`ifdef AUDIO_FEED_SW_DEBOUNCE_PULSE_EN
    logic [N_SW-1:0] r_prev;
    logic [N_SW-1:0] r_rise;
    logic [N_SW-1:0] r_fall;

    // Edge pulses land the cycle after sw_out moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_prev <= w_sw_out;
            r_rise <= w_sw_out & ~r_prev;
            r_fall <= ~w_sw_out & r_prev;
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
`endif

endmodule
